// File: rtl/inducer_pkg.sv
// Shared definitions for the inducer sampler.
//   state_t               : debounce FSM states
//   IN_W                  : number of inducer inputs ({in1,in2,in3})
//   STABLE_CYCLES_DEFAULT : default debounce length in synchronized samples
package inducer_pkg;

    localparam int IN_W = 3;
    localparam int STABLE_CYCLES_DEFAULT = 4;

    typedef enum logic {
        IDLE   = 1'b0,  // synchronized input equals the accepted stable value
        SETTLE = 1'b1   // a differing candidate is being debounced
    } state_t;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
// Each bit is synchronized on its own; no coherency between bits is implied.
// Ports:
//   clk   : sampling clock, rising edge
//   rst_n : asynchronous active-low reset, clears both stages to 0
//   d     : asynchronous input levels
//   q     : second-stage (synchronized) levels
module input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/inducer_sampler.sv
// Inducer sampler: synchronizes and debounces three asynchronous inducer
// levels and presents each newly settled vector to the downstream
// truth-table stage over a valid/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   raw_in    : asynchronous inducer levels {in1,in2,in3}
//   out_ready : downstream accepts out_bits this cycle
//   out_valid : out_bits holds a new debounced vector
//   out_bits  : debounced {in1,in2,in3}
//   dropped   : sticky, some debounced vector was never presented
module inducer_sampler
    import inducer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] raw_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IN_W-1:0] out_bits,
    output logic            dropped
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [IN_W-1:0]  sync2;
    state_t           state_reg;
    logic [IN_W-1:0]  candidate_reg;
    logic [IN_W-1:0]  stable_reg;
    logic [IN_W-1:0]  last_sent_reg;
    logic [IN_W-1:0]  out_bits_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_valid_reg;
    logic             dropped_reg;
    logic             stable_load;

    input_sync #(
        .WIDTH (IN_W)
    ) u_input_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (sync2)
    );

    // The candidate has survived its final debounce sample this cycle.
    assign stable_load = (state_reg == SETTLE) && (sync2 == candidate_reg)
                         && (cnt_reg == CNT_MAX);

    // Debounce FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            candidate_reg <= '0;
            stable_reg    <= '0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sync2 != stable_reg) begin
                        candidate_reg <= sync2;
                        cnt_reg       <= '0;
                        state_reg     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2 == candidate_reg) begin
                        if (cnt_reg == CNT_MAX) begin
                            stable_reg <= candidate_reg;
                            state_reg  <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end else if (sync2 == stable_reg) begin
                        // Short excursion that returned to the old value.
                        state_reg <= IDLE;
                    end else begin
                        // A third value appeared; restart on it.
                        candidate_reg <= sync2;
                        cnt_reg       <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output handshake. Acceptance takes priority, so out_valid is always
    // low for at least one cycle between presentations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_bits_reg  <= '0;
            last_sent_reg <= '0;
            dropped_reg   <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                last_sent_reg <= out_bits_reg;
                out_valid_reg <= 1'b0;
            end else if (!out_valid_reg && (stable_reg != last_sent_reg)) begin
                out_bits_reg  <= stable_reg;
                out_valid_reg <= 1'b1;
            end
            // While stalled, the only vector that can be lost is the one
            // currently held in stable_reg but not yet copied to out_bits.
            if (out_valid_reg && !out_ready && stable_load
                && (candidate_reg != stable_reg)
                && (stable_reg != out_bits_reg)) begin
                dropped_reg <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bits  = out_bits_reg;
    assign dropped   = dropped_reg;

endmodule
